osc_meas_ctrl: RTL and testbench
================================

# osc_meas_ctrl

Measurement controller for the GPIO ring-oscillator counter block, in the `ref_clk` domain. It owns the oscillator's control side: reset/halt, a fixed gate window, and the latch request/acknowledge handshake. It reads back the frozen oscillator count and presents it as a single-cycle-valid result to the register/host side. One instance pairs with one oscillator counter instance.

## Interface
Parameters:
- `GATE_CYCLES`, 1000, number of `ref_clk` cycles the oscillator runs with the counter enabled (1..2^32-1).
- `RST_CYCLES`, 4, number of `ref_clk` cycles `osc_rst` is held before a gate (>=2).
- `SETTLE_CYCLES`, 2, number of `ref_clk` cycles waited after `osc_latch_ack` rises before sampling `osc_counter_latch` (>=1).
- `ACK_TIMEOUT`, 1024, maximum `ref_clk` cycles to wait for any ack edge (>=8).

Ports:
- `ref_clk`, in, 1: the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: level-sampled request to begin one measurement; honoured only in IDLE.
- `osc_rst`, out, 1: to oscillator counter, async reset of its counters.
- `osc_halt`, out, 1: to oscillator, 1 = tri-state the loop (oscillation stopped).
- `osc_latch_req`, out, 1: to oscillator, freezes the count and requests a latch.
- `osc_latch_ack`, in, 1: from oscillator, already synchronized to `ref_clk`.
- `osc_counter_latch`, in, 32: latched oscillator count; quasi-static and valid only after SETTLE.
- `busy`, out, 1: high in every state except IDLE.
- `result`, out, 32: last measured count; holds until next DONE.
- `result_valid`, out, 1: one-cycle pulse in DONE.
- `timeout_err`, out, 1: sticky error for the last measurement; cleared when the next measurement starts.

## Operation
- States: IDLE, RESET, RUN, REQ, SETTLE, RELEASE, DONE. One 32-bit down-counter is shared across the timed states.
- Outputs by state:
  - IDLE: osc_rst=0, halt=1, req=0.
  - RESET: rst=1, halt=1, req=0.
  - RUN: rst=0, halt=0, req=0.
  - REQ, SETTLE, RELEASE: rst=0, halt=0. req=1 in REQ and SETTLE, req=0 in RELEASE.
  - DONE: halt=1, req=0.
- IDLE -> RESET when `start`=1. On this transition `timeout_err` clears and the counter loads RST_CYCLES-1.
- RESET -> RUN when the counter reaches 0. On this transition the counter loads GATE_CYCLES-1.
- RUN -> REQ when the counter reaches 0. On this transition the counter loads ACK_TIMEOUT-1.
- REQ:
  - When `osc_latch_ack`=1, go to SETTLE and load SETTLE_CYCLES-1.
  - Otherwise, when the counter reaches 0, set `timeout_err`, force `result`=0 and go to DONE.
- SETTLE -> RELEASE when the counter reaches 0. On this transition `result` <= `osc_counter_latch` and the counter loads ACK_TIMEOUT-1.
- RELEASE:
  - When `osc_latch_ack`=0, go to DONE.
  - On timeout, set `timeout_err`, keep the captured `result` and go to DONE.
- DONE -> IDLE unconditionally after 1 cycle. `result_valid`=1 only in DONE.
- The oscillator stays un-halted through RELEASE because the ack can only fall while the oscillator is producing edges.
- A dead oscillator (no edges) must not hang the controller; both ack waits are bounded by ACK_TIMEOUT.
- `start` is ignored outside IDLE. A `start` held high re-triggers a new measurement on the cycle after DONE.
- Counter decrements are modulo-free: counts never wrap because each is loaded before use. `result` is the raw 32-bit value, with no scaling.

## Timing
- Reset values:
  - state=IDLE.
  - `osc_rst`=1 while `rst` is asserted; it is 0 once IDLE is registered.
  - `osc_halt`=1, `osc_latch_req`=0, `busy`=0, `result`=0, `result_valid`=0, `timeout_err`=0.
- `rst` asserted mid-operation: the state returns to IDLE asynchronously, `osc_latch_req` drops and `osc_halt` rises immediately. `result` is cleared and no `result_valid` is issued.
- All outputs are registered. `start` high at edge 0 gives `osc_rst`=1 from edge 1 for exactly RST_CYCLES cycles.
- RUN lasts exactly GATE_CYCLES cycles (osc_rst=0 and req=0).
- Minimum latency from `start` to `result_valid` with an ack after A cycles and an ack fall after F cycles: 1 + RST_CYCLES + GATE_CYCLES + A + SETTLE_CYCLES + F + 1.
- `osc_counter_latch` is sampled on the last SETTLE cycle only.

## Test plan
- Nominal:
  - Setup: GATE_CYCLES=100, with an oscillator model whose counter equals 143 when frozen; ack follows req with a 2-cycle delay on both edges.
  - Required: `result_valid` pulses once, `result`=143, `timeout_err`=0, `busy` falls the same cycle as DONE exits, `osc_halt`=1 afterwards.
- Dead oscillator:
  - Setup: ack is tied low.
  - Required: `osc_latch_req` is held for exactly 1024 cycles, then `result`=0, `timeout_err`=1 and `result_valid` pulses once.
- Stuck ack:
  - Setup: ack rises normally but never falls.
  - Required: the captured `result` is kept, `timeout_err`=1, and DONE follows after 1024 RELEASE cycles.
- Start while busy:
  - Stimulus: `start` pulses during RUN and during REQ.
  - Required: no restart and the gate length is unchanged. A subsequent `start` after an error run clears `timeout_err` on entry to RESET.
- Reset mid-RUN:
  - Stimulus: assert `rst` for 1 cycle at gate cycle 50.
  - Required: `osc_halt`=1 and req=0 asynchronously, and no `result_valid`. The next `start` performs a full measurement.
- Continuous `start`=1:
  - Required: back-to-back measurements with exactly one IDLE cycle between DONE and RESET. Each `result_valid` carries that run's count.

Source files
------------

// File: rtl/osc_meas_ctrl.sv
// osc_meas_ctrl: sequences one ring-oscillator measurement.
// The sequence is reset, a fixed gate window, a latch request/ack handshake,
// capture of the frozen count, and release. The result is presented as a
// one-cycle valid pulse.
//
// state   | meaning
// IDLE    | oscillator halted, waiting for start
// RESET   | counter held in reset for RST_CYCLES
// RUN     | gate window, oscillator counting for GATE_CYCLES
// REQ     | latch requested, waiting (bounded) for ack rise
// SETTLE  | ack seen, letting the latched count settle
// RELEASE | request dropped, waiting (bounded) for ack fall
// DONE    | one-cycle result_valid, then back to IDLE
module osc_meas_ctrl #(
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT   = 1024
) (
  input  logic        ref_clk,
  input  logic        rst,
  input  logic        start,
  output logic        osc_rst,
  output logic        osc_halt,
  output logic        osc_latch_req,
  input  logic        osc_latch_ack,
  input  logic [31:0] osc_counter_latch,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        timeout_err
);

  localparam logic [31:0] LP_RST_LOAD    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LP_GATE_LOAD   = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] LP_SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] LP_ACK_LOAD    = 32'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_REQ, S_SETTLE, S_RELEASE, S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        w_cnt_zero;

  assign w_cnt_zero = (r_cnt == 32'd0);

  // Control outputs for a state: {osc_rst, osc_halt, osc_latch_req, busy}.
  // Outputs are registered from the next state, so they line up with it.
  function automatic logic [3:0] f_outs(input state_t s);
    logic [3:0] v;
    case (s)
      S_IDLE:    v = 4'b0100;
      S_RESET:   v = 4'b1101;
      S_RUN:     v = 4'b0001;
      S_REQ:     v = 4'b0011;
      S_SETTLE:  v = 4'b0011;
      S_RELEASE: v = 4'b0001;
      S_DONE:    v = 4'b0101;
      default:   v = 4'b0100;
    endcase
    return v;
  endfunction

  // Measurement sequencer with shared down-counter and registered outputs.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 32'd0;
      osc_rst       <= 1'b1;
      osc_halt      <= 1'b1;
      osc_latch_req <= 1'b0;
      busy          <= 1'b0;
      result        <= 32'd0;
      result_valid  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RESET;
            r_cnt       <= LP_RST_LOAD;
            timeout_err <= 1'b0;
            {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_RESET);
          end else begin
            {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_IDLE);
          end
        end
        S_RESET: begin
          if (w_cnt_zero) begin
            r_state <= S_RUN;
            r_cnt   <= LP_GATE_LOAD;
            {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_RUN);
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_RUN: begin
          if (w_cnt_zero) begin
            r_state <= S_REQ;
            r_cnt   <= LP_ACK_LOAD;
            {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_REQ);
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_REQ: begin
          if (osc_latch_ack) begin
            r_state <= S_SETTLE;
            r_cnt   <= LP_SETTLE_LOAD;
            {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_SETTLE);
          end else if (w_cnt_zero) begin
            // No ack ever came: dead oscillator, nothing valid to report.
            r_state      <= S_DONE;
            timeout_err  <= 1'b1;
            result       <= 32'd0;
            result_valid <= 1'b1;
            {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_DONE);
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_SETTLE: begin
          if (w_cnt_zero) begin
            r_state <= S_RELEASE;
            r_cnt   <= LP_ACK_LOAD;
            result  <= osc_counter_latch;
            {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_RELEASE);
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_RELEASE: begin
          if (!osc_latch_ack || w_cnt_zero) begin
            // A stuck ack still keeps the count captured in SETTLE.
            r_state      <= S_DONE;
            result_valid <= 1'b1;
            if (osc_latch_ack) timeout_err <= 1'b1;
            {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_DONE);
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_IDLE);
        end
        default: begin
          r_state <= S_IDLE;
          {osc_rst, osc_halt, osc_latch_req, busy} <= f_outs(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_meas_ctrl.sv
// Testbench for osc_meas_ctrl: oscillator/ack model plus expected-result queue.
module tb_osc_meas_ctrl;

  localparam int GATE   = 100;
  localparam int RSTC   = 4;
  localparam int SETTLE = 2;
  localparam int ACKTO  = 1024;

  logic        ref_clk;
  logic        rst;
  logic        start;
  logic        osc_rst;
  logic        osc_halt;
  logic        osc_latch_req;
  logic        osc_latch_ack;
  logic [31:0] osc_counter_latch;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        timeout_err;

  logic [31:0] latch_val;
  logic        req_d1;
  int          ack_mode;   // 0 normal, 1 tied low, 2 rises but never falls
  int          n_tests;
  int          n_fail;
  int          n_valid;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  osc_meas_ctrl #(
    .GATE_CYCLES(GATE), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(ACKTO)
  ) dut (
    .ref_clk(ref_clk), .rst(rst), .start(start),
    .osc_rst(osc_rst), .osc_halt(osc_halt), .osc_latch_req(osc_latch_req),
    .osc_latch_ack(osc_latch_ack), .osc_counter_latch(osc_counter_latch),
    .busy(busy), .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  initial begin
    ref_clk = 1'b0;
    forever #5 ref_clk = ~ref_clk;
  end

  // Oscillator side: ack follows req two edges later on both edges.
  always @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      req_d1        <= 1'b0;
      osc_latch_ack <= 1'b0;
    end else begin
      req_d1 <= osc_latch_req;
      case (ack_mode)
        0:       osc_latch_ack <= req_d1;
        1:       osc_latch_ack <= 1'b0;
        default: osc_latch_ack <= osc_latch_ack | req_d1;
      endcase
    end
  end

  // Frozen count is only meaningful while the ack is high.
  assign osc_counter_latch = osc_latch_ack ? latch_val : 32'hDEAD_BEEF;

  // Count every result_valid cycle seen.
  always @(negedge ref_clk) begin
    if (result_valid === 1'b1) n_valid <= n_valid + 1;
  end

  // Drive one measurement from IDLE and record phase lengths; called at a negedge.
  task automatic do_meas(input bit pulse_busy, output bit err_at_start,
                         output int rst_len, output int gate_len, output int req_len,
                         output int rel_len, output bit got_valid,
                         output logic [31:0] res, output logic err);
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    err_at_start = timeout_err;
    rst_len = 0;
    while (osc_rst === 1'b1 && rst_len < 64) begin
      rst_len++;
      @(negedge ref_clk);
    end
    gate_len = 0;
    while (osc_latch_req !== 1'b1 && gate_len < 5000) begin
      start = pulse_busy && (gate_len == 10);
      gate_len++;
      @(negedge ref_clk);
    end
    start = 1'b0;
    req_len = 0;
    while (osc_latch_req === 1'b1 && req_len < 5000) begin
      start = pulse_busy && (req_len == 1);
      req_len++;
      @(negedge ref_clk);
    end
    start = 1'b0;
    rel_len = 0;
    while (result_valid !== 1'b1 && rel_len < 5000) begin
      rel_len++;
      @(negedge ref_clk);
    end
    got_valid = (result_valid === 1'b1);
    res = result;
    err = timeout_err;
    @(negedge ref_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge ref_clk);
    n_tests++; if (osc_rst !== 1'b1) begin n_fail++; $display("FAIL reset_osc_rst: got %b expected 1", osc_rst); end
    n_tests++; if (osc_halt !== 1'b1) begin n_fail++; $display("FAIL reset_halt: got %b expected 1", osc_halt); end
    n_tests++; if (osc_latch_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", osc_latch_req); end
    n_tests++; if ({busy, result_valid, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, result_valid, timeout_err}); end
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b0;
    @(negedge ref_clk);
    n_tests++; if (osc_rst !== 1'b0) begin n_fail++; $display("FAIL idle_osc_rst: got %b expected 0", osc_rst); end
    n_tests++; if ({busy, osc_halt} !== 2'b01) begin n_fail++; $display("FAIL idle_busy_halt: got %b expected 01", {busy, osc_halt}); end
  endtask

  task automatic test_nominal();
    bit eas, gv; int rl, gl, ql, ll, v0; logic [31:0] r; logic e; exp_t x;
    ack_mode = 0;
    latch_val = 32'd143;
    sb_q.push_back('{res: 32'd143, err: 1'b0});
    v0 = n_valid;
    do_meas(1'b0, eas, rl, gl, ql, ll, gv, r, e);
    x = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_tests++; if (gv !== 1'b1) begin n_fail++; $display("FAIL nom_valid: got %b expected 1", gv); end
    n_tests++; if (r !== x.res) begin n_fail++; $display("FAIL nom_result: got %0d expected %0d", r, x.res); end
    n_tests++; if (e !== x.err) begin n_fail++; $display("FAIL nom_err: got %b expected %b", e, x.err); end
    n_tests++; if (rl !== RSTC) begin n_fail++; $display("FAIL nom_rst_len: got %0d expected %0d", rl, RSTC); end
    n_tests++; if (gl !== GATE) begin n_fail++; $display("FAIL nom_gate_len: got %0d expected %0d", gl, GATE); end
    n_tests++; if (ql !== 3 + SETTLE) begin n_fail++; $display("FAIL nom_req_len: got %0d expected %0d", ql, 3 + SETTLE); end
    n_tests++; if (ll !== 3) begin n_fail++; $display("FAIL nom_release_len: got %0d expected 3", ll); end
    n_tests++; if ({busy, osc_halt, result_valid} !== 3'b010) begin n_fail++; $display("FAIL nom_after_done: busy/halt/valid got %b expected 010", {busy, osc_halt, result_valid}); end
    n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL nom_pulses: got %0d expected 1", n_valid - v0); end
  endtask

  task automatic test_dead();
    bit eas, gv; int rl, gl, ql, ll, v0; logic [31:0] r; logic e; exp_t x;
    ack_mode = 1;
    latch_val = 32'd143;
    sb_q.push_back('{res: 32'd0, err: 1'b1});
    v0 = n_valid;
    do_meas(1'b0, eas, rl, gl, ql, ll, gv, r, e);
    x = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_tests++; if (gv !== 1'b1) begin n_fail++; $display("FAIL dead_valid: got %b expected 1", gv); end
    n_tests++; if (ql !== ACKTO) begin n_fail++; $display("FAIL dead_req_len: got %0d expected %0d", ql, ACKTO); end
    n_tests++; if (ll !== 0) begin n_fail++; $display("FAIL dead_release_len: got %0d expected 0", ll); end
    n_tests++; if (r !== x.res) begin n_fail++; $display("FAIL dead_result: got %h expected %h", r, x.res); end
    n_tests++; if (e !== x.err) begin n_fail++; $display("FAIL dead_err: got %b expected %b", e, x.err); end
    n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL dead_pulses: got %0d expected 1", n_valid - v0); end
  endtask

  task automatic test_start_while_busy();
    bit eas, gv; int rl, gl, ql, ll; logic [31:0] r; logic e; exp_t x;
    ack_mode = 0;
    latch_val = 32'd777;
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL swb_err_sticky: got %b expected 1", timeout_err); end
    sb_q.push_back('{res: 32'd777, err: 1'b0});
    do_meas(1'b1, eas, rl, gl, ql, ll, gv, r, e);
    x = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_tests++; if (eas !== 1'b0) begin n_fail++; $display("FAIL swb_err_clear: got %b expected 0", eas); end
    n_tests++; if (rl !== RSTC) begin n_fail++; $display("FAIL swb_rst_len: got %0d expected %0d", rl, RSTC); end
    n_tests++; if (gl !== GATE) begin n_fail++; $display("FAIL swb_gate_len: got %0d expected %0d", gl, GATE); end
    n_tests++; if (ql !== 3 + SETTLE) begin n_fail++; $display("FAIL swb_req_len: got %0d expected %0d", ql, 3 + SETTLE); end
    n_tests++; if ({gv, r} !== {1'b1, x.res}) begin n_fail++; $display("FAIL swb_result: valid %b result %0d expected 1 %0d", gv, r, x.res); end
    n_tests++; if (e !== x.err) begin n_fail++; $display("FAIL swb_err: got %b expected %b", e, x.err); end
    repeat (3) @(negedge ref_clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swb_no_restart: busy got %b expected 0", busy); end
  endtask

  task automatic test_stuck();
    bit eas, gv; int rl, gl, ql, ll; logic [31:0] r; logic e; exp_t x;
    ack_mode = 2;
    latch_val = 32'h1234_5678;
    sb_q.push_back('{res: 32'h1234_5678, err: 1'b1});
    do_meas(1'b0, eas, rl, gl, ql, ll, gv, r, e);
    x = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_tests++; if (gv !== 1'b1) begin n_fail++; $display("FAIL stuck_valid: got %b expected 1", gv); end
    n_tests++; if (ql !== 3 + SETTLE) begin n_fail++; $display("FAIL stuck_req_len: got %0d expected %0d", ql, 3 + SETTLE); end
    n_tests++; if (ll !== ACKTO) begin n_fail++; $display("FAIL stuck_release_len: got %0d expected %0d", ll, ACKTO); end
    n_tests++; if (r !== x.res) begin n_fail++; $display("FAIL stuck_result: got %h expected %h", r, x.res); end
    n_tests++; if (e !== x.err) begin n_fail++; $display("FAIL stuck_err: got %b expected %b", e, x.err); end
    ack_mode = 0;
    repeat (3) @(negedge ref_clk);
  endtask

  task automatic test_reset_mid_run();
    bit eas, gv; int rl, gl, ql, ll, v0, k; logic [31:0] r; logic e; exp_t x;
    ack_mode = 0;
    latch_val = 32'd55;
    v0 = n_valid;
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    k = 0;
    while (osc_rst === 1'b1 && k < 64) begin k++; @(negedge ref_clk); end
    repeat (50) @(negedge ref_clk);
    n_tests++; if ({osc_halt, osc_latch_req, busy} !== 3'b001) begin n_fail++; $display("FAIL rmr_in_run: halt/req/busy got %b expected 001", {osc_halt, osc_latch_req, busy}); end
    rst = 1'b1;
    #1;
    n_tests++; if ({osc_halt, osc_latch_req, osc_rst} !== 3'b101) begin n_fail++; $display("FAIL rmr_async: halt/req/osc_rst got %b expected 101", {osc_halt, osc_latch_req, osc_rst}); end
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL rmr_result_clr: got %h expected 0", result); end
    @(negedge ref_clk);
    rst = 1'b0;
    repeat (20) @(negedge ref_clk);
    n_tests++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL rmr_no_valid: got %0d pulses expected 0", n_valid - v0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmr_idle: busy got %b expected 0", busy); end
    sb_q.push_back('{res: 32'd55, err: 1'b0});
    do_meas(1'b0, eas, rl, gl, ql, ll, gv, r, e);
    x = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_tests++; if ({gv, rl, gl} !== {1'b1, RSTC, GATE}) begin n_fail++; $display("FAIL rmr_full_run: valid %b rst_len %0d gate_len %0d expected 1 %0d %0d", gv, rl, gl, RSTC, GATE); end
    n_tests++; if ({r, e} !== {x.res, x.err}) begin n_fail++; $display("FAIL rmr_result: got %0d/%b expected %0d/%b", r, e, x.res, x.err); end
  endtask

  task automatic test_back_to_back();
    int k; exp_t x;
    ack_mode = 0;
    start = 1'b1;
    for (int run = 0; run < 3; run++) begin
      latch_val = 32'd1000 + 32'(run);
      sb_q.push_back('{res: 32'd1000 + 32'(run), err: 1'b0});
      k = 0;
      while (result_valid !== 1'b1 && k < 2000) begin k++; @(negedge ref_clk); end
      x = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_tests++; if ({result_valid, result} !== {1'b1, x.res}) begin n_fail++; $display("FAIL b2b_result run %0d: valid %b result %0d expected 1 %0d", run, result_valid, result, x.res); end
      if (run == 2) start = 1'b0;
      @(negedge ref_clk);
      n_tests++; if ({busy, osc_rst} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle run %0d: busy/osc_rst got %b expected 00", run, {busy, osc_rst}); end
      @(negedge ref_clk);
      if (run < 2) begin
        n_tests++; if ({busy, osc_rst} !== 2'b11) begin n_fail++; $display("FAIL b2b_restart run %0d: busy/osc_rst got %b expected 11", run, {busy, osc_rst}); end
      end else begin
        n_tests++; if ({busy, osc_rst} !== 2'b00) begin n_fail++; $display("FAIL b2b_stop: busy/osc_rst got %b expected 00", {busy, osc_rst}); end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    n_valid = 0;
    ack_mode = 0;
    latch_val = 32'd0;
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_nominal();
    test_dead();
    test_start_while_busy();
    test_stuck();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
